stream_minmax_tracker: RTL and testbench



---
 rtl/stream_minmax_tracker_pkg.sv | 20 ++
 rtl/stream_minmax_tracker_mag_cmp.sv | 25 ++
 rtl/stream_minmax_tracker.sv | 120 ++++++++++++
 tb/tb_stream_minmax_tracker.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/stream_minmax_tracker_pkg.sv
// Shared types for the frame min/max tracker: FSM states, comparator flags and
// the default counter width with its saturation value.
package cmp_pkg;

  typedef enum logic [1:0] {
    S_FIRST = 2'd0,
    S_ACC   = 2'd1,
    S_OUT   = 2'd2
  } state_t;

  typedef struct packed {
    logic gt;
    logic lt;
    logic eq;
  } cmp_flags_t;

  localparam int CNT_W_DEFAULT = 16;
  localparam longint unsigned CNT_SAT_DEFAULT = (64'd1 << CNT_W_DEFAULT) - 64'd1;

endpackage

// File: rtl/stream_minmax_tracker_mag_cmp.sv
// Combinational magnitude comparator, unsigned or two's-complement.
module mag_cmp #(
  parameter int WIDTH  = 8,
  parameter bit SIGNED = 1'b0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             a_gt_b,
  output logic             a_lt_b,
  output logic             a_eq_b
);

  generate
    if (SIGNED) begin : g_signed
      assign a_gt_b = $signed(a) > $signed(b);
      assign a_lt_b = $signed(a) < $signed(b);
    end else begin : g_unsigned
      assign a_gt_b = a > b;
      assign a_lt_b = a < b;
    end
  endgenerate

  assign a_eq_b = (a == b);

endmodule

// File: rtl/stream_minmax_tracker.sv
// Tracks the per-frame maximum/minimum of a valid/ready sample stream, with the
// index of each extreme's first occurrence, a saturating sample count and an all-equal flag.
module stream_minmax_tracker
  import cmp_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int CNT_W  = CNT_W_DEFAULT,
  parameter bit SIGNED = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_max,
  output logic [WIDTH-1:0] out_min,
  output logic [CNT_W-1:0] out_max_idx,
  output logic [CNT_W-1:0] out_min_idx,
  output logic [CNT_W-1:0] out_count,
  output logic             out_all_eq
);

  localparam logic [CNT_W-1:0] CNT_SAT = '1;

  state_t           state;
  logic [WIDTH-1:0] max_r;
  logic [WIDTH-1:0] min_r;
  logic [CNT_W-1:0] max_idx_r;
  logic [CNT_W-1:0] min_idx_r;
  logic [CNT_W-1:0] cnt_r;
  logic             all_eq_r;

  cmp_flags_t       max_flags;
  cmp_flags_t       min_flags;
  logic             accept;
  logic [CNT_W-1:0] cnt_next;

  // Both comparisons see the stored extremes, never same-cycle updates.
  mag_cmp #(.WIDTH(WIDTH), .SIGNED(SIGNED)) u_cmp_max (
    .a      (in_data),
    .b      (max_r),
    .a_gt_b (max_flags.gt),
    .a_lt_b (max_flags.lt),
    .a_eq_b (max_flags.eq)
  );

  mag_cmp #(.WIDTH(WIDTH), .SIGNED(SIGNED)) u_cmp_min (
    .a      (in_data),
    .b      (min_r),
    .a_gt_b (min_flags.gt),
    .a_lt_b (min_flags.lt),
    .a_eq_b (min_flags.eq)
  );

  assign in_ready = (state != S_OUT);
  assign accept   = in_valid && in_ready;
  assign cnt_next = (cnt_r == CNT_SAT) ? cnt_r : cnt_r + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_FIRST;
      max_r     <= '0;
      min_r     <= '0;
      max_idx_r <= '0;
      min_idx_r <= '0;
      cnt_r     <= '0;
      all_eq_r  <= 1'b0;
    end else begin
      case (state)
        S_FIRST: begin
          if (accept) begin
            max_r     <= in_data;
            min_r     <= in_data;
            max_idx_r <= '0;
            min_idx_r <= '0;
            cnt_r     <= CNT_W'(1);
            all_eq_r  <= 1'b1;
            state     <= in_last ? S_OUT : S_ACC;
          end
        end
        S_ACC: begin
          if (accept) begin
            // Strict compares keep the index of the first occurrence on ties.
            if (max_flags.gt) begin
              max_r     <= in_data;
              max_idx_r <= cnt_r;
            end
            if (min_flags.lt) begin
              min_r     <= in_data;
              min_idx_r <= cnt_r;
            end
            if (!max_flags.eq) all_eq_r <= 1'b0;
            cnt_r <= cnt_next;
            if (in_last) state <= S_OUT;
          end
        end
        S_OUT: begin
          if (out_ready) state <= S_FIRST;
        end
        default: state <= S_FIRST;
      endcase
    end
  end

  assign out_valid   = (state == S_OUT);
  assign out_max     = max_r;
  assign out_min     = min_r;
  assign out_max_idx = max_idx_r;
  assign out_min_idx = min_idx_r;
  assign out_count   = cnt_r;
  assign out_all_eq  = all_eq_r;

  // Unused comparator flags are kept for symmetry of the two instances.
  logic unused_flags;
  assign unused_flags = ^{max_flags.lt, min_flags.gt, min_flags.eq};

endmodule

// File: tb/tb_stream_minmax_tracker.sv
// Directed bench for stream_minmax_tracker: three configurations (unsigned,
// signed, 2-bit counter) share one stimulus bus, results checked via a scoreboard queue.
module tb_stream_minmax_tracker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_last;
  logic       out_ready;
  int         sel;

  logic        rdy_a, vld_a, eq_a;
  logic [7:0]  max_a, min_a;
  logic [15:0] mxi_a, mni_a, cnt_a;
  logic        rdy_b, vld_b, eq_b;
  logic [7:0]  max_b, min_b;
  logic [15:0] mxi_b, mni_b, cnt_b;
  logic        rdy_c, vld_c, eq_c;
  logic [7:0]  max_c, min_c;
  logic [1:0]  mxi_c, mni_c, cnt_c;

  logic iv_a, iv_b, iv_c, or_a, or_b, or_c;
  assign iv_a = in_valid && (sel == 0);
  assign iv_b = in_valid && (sel == 1);
  assign iv_c = in_valid && (sel == 2);
  assign or_a = out_ready && (sel == 0);
  assign or_b = out_ready && (sel == 1);
  assign or_c = out_ready && (sel == 2);

  stream_minmax_tracker #(.WIDTH(8), .CNT_W(16), .SIGNED(1'b0)) dut_a (
    .clk(clk), .rst(rst), .in_valid(iv_a), .in_ready(rdy_a), .in_data(in_data),
    .in_last(in_last), .out_valid(vld_a), .out_ready(or_a), .out_max(max_a),
    .out_min(min_a), .out_max_idx(mxi_a), .out_min_idx(mni_a), .out_count(cnt_a),
    .out_all_eq(eq_a));

  stream_minmax_tracker #(.WIDTH(8), .CNT_W(16), .SIGNED(1'b1)) dut_b (
    .clk(clk), .rst(rst), .in_valid(iv_b), .in_ready(rdy_b), .in_data(in_data),
    .in_last(in_last), .out_valid(vld_b), .out_ready(or_b), .out_max(max_b),
    .out_min(min_b), .out_max_idx(mxi_b), .out_min_idx(mni_b), .out_count(cnt_b),
    .out_all_eq(eq_b));

  stream_minmax_tracker #(.WIDTH(8), .CNT_W(2), .SIGNED(1'b0)) dut_c (
    .clk(clk), .rst(rst), .in_valid(iv_c), .in_ready(rdy_c), .in_data(in_data),
    .in_last(in_last), .out_valid(vld_c), .out_ready(or_c), .out_max(max_c),
    .out_min(min_c), .out_max_idx(mxi_c), .out_min_idx(mni_c), .out_count(cnt_c),
    .out_all_eq(eq_c));

  logic        c_rdy, c_vld, c_eq;
  logic [7:0]  c_max, c_min;
  logic [15:0] c_mxi, c_mni, c_cnt;

  always_comb begin
    c_rdy = rdy_a; c_vld = vld_a; c_eq = eq_a; c_max = max_a; c_min = min_a;
    c_mxi = mxi_a; c_mni = mni_a; c_cnt = cnt_a;
    if (sel == 1) begin
      c_rdy = rdy_b; c_vld = vld_b; c_eq = eq_b; c_max = max_b; c_min = min_b;
      c_mxi = mxi_b; c_mni = mni_b; c_cnt = cnt_b;
    end else if (sel == 2) begin
      c_rdy = rdy_c; c_vld = vld_c; c_eq = eq_c; c_max = max_c; c_min = min_c;
      c_mxi = {14'd0, mxi_c}; c_mni = {14'd0, mni_c}; c_cnt = {14'd0, cnt_c};
    end
  end

  typedef struct {
    logic [7:0]  mx;
    logic [7:0]  mn;
    logic [15:0] mxi;
    logic [15:0] mni;
    logic [15:0] cnt;
    logic        eq;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [7:0] mx, input logic [7:0] mn, input logic [15:0] mxi,
                          input logic [15:0] mni, input logic [15:0] cnt, input logic eq);
    exp_t e;
    e.mx = mx; e.mn = mn; e.mxi = mxi; e.mni = mni; e.cnt = cnt; e.eq = eq;
    sb.push_back(e);
  endtask

  // Offer one sample and hold it until accepted (bounded).
  task automatic send(input logic [7:0] d, input logic l);
    int n = 0;
    in_valid = 1'b1; in_data = d; in_last = l;
    while (!c_rdy && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) chk("send_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  // Wait (bounded) for a result and compare it against the scoreboard head.
  task automatic get_result(input string tag);
    int   n = 0;
    exp_t e;
    while (!c_vld && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!c_vld) begin
      chk({tag, "_timeout"}, 32'd0, 32'd1);
    end else if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_max"},     {24'd0, c_max}, {24'd0, e.mx});
      chk({tag, "_min"},     {24'd0, c_min}, {24'd0, e.mn});
      chk({tag, "_max_idx"}, {16'd0, c_mxi}, {16'd0, e.mxi});
      chk({tag, "_min_idx"}, {16'd0, c_mni}, {16'd0, e.mni});
      chk({tag, "_count"},   {16'd0, c_cnt}, {16'd0, e.cnt});
      chk({tag, "_all_eq"},  {31'd0, c_eq},  {31'd0, e.eq});
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0; sel = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, c_rdy}, 32'd1);
    chk("rst_out_valid", {31'd0, c_vld}, 32'd0);
    chk("rst_max", {24'd0, c_max}, 32'd0);
    chk("rst_count", {16'd0, c_cnt}, 32'd0);
    chk("rst_all_eq", {31'd0, c_eq}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Frame 5,9,2,9,2 with the consumer always ready.
    out_ready = 1'b1;
    push_exp(8'd9, 8'd2, 16'd1, 16'd2, 16'd5, 1'b0);
    send(8'd5, 1'b0); send(8'd9, 1'b0); send(8'd2, 1'b0); send(8'd9, 1'b0);
    send(8'd2, 1'b1);
    chk("f1_valid_after_last", {31'd0, c_vld}, 32'd1);
    get_result("f1");
    @(posedge clk); #1;
    chk("f1_valid_one_cycle", {31'd0, c_vld}, 32'd0);
    chk("f1_in_ready_back", {31'd0, c_rdy}, 32'd1);

    // Frame 7,7,7 with backpressure; an extra sample is offered meanwhile.
    out_ready = 1'b0;
    push_exp(8'd7, 8'd7, 16'd0, 16'd0, 16'd3, 1'b1);
    send(8'd7, 1'b0); send(8'd7, 1'b0); send(8'd7, 1'b1);
    in_valid = 1'b1; in_data = 8'h55; in_last = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("bp_valid", {31'd0, c_vld}, 32'd1);
      chk("bp_in_ready", {31'd0, c_rdy}, 32'd0);
      chk("bp_max_stable", {24'd0, c_max}, 32'd7);
      chk("bp_count_stable", {16'd0, c_cnt}, 32'd3);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_last = 1'b0;
    get_result("bp");
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_handoff_valid", {31'd0, c_vld}, 32'd0);
    chk("bp_handoff_in_ready", {31'd0, c_rdy}, 32'd1);

    // Single-sample frame.
    push_exp(8'h33, 8'h33, 16'd0, 16'd0, 16'd1, 1'b1);
    send(8'h33, 1'b1);
    get_result("single");
    @(posedge clk); #1;

    // Signed compare: 0x80 is the most negative value.
    sel = 1;
    push_exp(8'h7F, 8'h80, 16'd1, 16'd0, 16'd3, 1'b0);
    send(8'h80, 1'b0); send(8'h7F, 1'b0); send(8'h00, 1'b1);
    get_result("signed");
    @(posedge clk); #1;

    // Saturating 2-bit counter.
    sel = 2;
    push_exp(8'd9, 8'd0, 16'd3, 16'd0, 16'd3, 1'b0);
    send(8'd0, 1'b0); send(8'd0, 1'b0); send(8'd0, 1'b0); send(8'd0, 1'b0);
    send(8'd9, 1'b1);
    get_result("sat");
    @(posedge clk); #1;

    // Reset mid-frame with a sample presented during the reset cycle.
    sel = 0;
    send(8'd200, 1'b0); send(8'd100, 1'b0);
    rst = 1'b1; in_valid = 1'b1; in_data = 8'hEE; in_last = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    chk("mid_rst_in_ready", {31'd0, c_rdy}, 32'd1);
    chk("mid_rst_out_valid", {31'd0, c_vld}, 32'd0);
    chk("mid_rst_count", {16'd0, c_cnt}, 32'd0);
    push_exp(8'd4, 8'd1, 16'd0, 16'd1, 16'd2, 1'b0);
    send(8'd4, 1'b0); send(8'd1, 1'b1);
    get_result("after_rst");
    @(posedge clk); #1;
    chk("sb_drained", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
